fifo_byte_serializer: RTL and testbench

//  Read-side consumer for the team's 8-deep byte FIFO (ren/dout/error interface).

---
 rtl/fifo_byte_serializer_pkg.sv | 20 ++
 rtl/fifo_byte_serializer_if.sv | 43 ++++
 rtl/fifo_byte_serializer_piso_shift.sv | 48 ++++
 rtl/fifo_byte_serializer.sv | 149 ++++++++++++++
 tb/tb_fifo_byte_serializer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_byte_serializer_pkg.sv
// rtl/fifo_byte_serializer_pkg.sv - shared types and constants for the FIFO byte serializer
// Purpose: FSM state encoding, FIFO data width, saturating counter helper.
// Ports: none (package).
package fifo_byte_serializer_pkg;

  localparam int FIFO_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_BACKOFF = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// rtl/fifo_byte_serializer_if.sv - FIFO read port plus serial stream bundle
// Purpose: groups the FIFO read handshake and the bit-serial tx handshake.
// Signals:
//   fifo_ren   read strobe to FIFO
//   fifo_dout  FIFO read data, valid the cycle after fifo_ren
//   fifo_error FIFO empty-read flag, valid the cycle after fifo_ren
//   tx_valid / tx_ready / tx_bit / tx_last  serial stream handshake
// Modports: master = serializer side, slave = FIFO + downstream side.
interface fifo_byte_serializer_if
  import fifo_byte_serializer_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) ();

  logic              fifo_ren;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_error;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_bit;
  logic              tx_last;

  modport master (
    output fifo_ren,
    input  fifo_dout,
    input  fifo_error,
    output tx_valid,
    input  tx_ready,
    output tx_bit,
    output tx_last
  );

  modport slave (
    input  fifo_ren,
    output fifo_dout,
    output fifo_error,
    input  tx_valid,
    output tx_ready,
    input  tx_bit,
    input  tx_last
  );

endinterface

// File: rtl/fifo_byte_serializer_piso_shift.sv
// rtl/fifo_byte_serializer_piso_shift.sv - parallel-load serial-out shift register
// Purpose: loads a W-bit frame and presents it one bit at a time, MSB or LSB first.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        load data_i (has priority over shift_i)
//   data_i        parallel frame
//   shift_i       advance to the next bit
//   bit_o         current serial bit
module fifo_byte_serializer_piso_shift #(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         bit_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      // zeros fill behind so an idle register reads back as 0
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[W-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = (MSB_FIRST != 0) ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/fifo_byte_serializer.sv
// rtl/fifo_byte_serializer.sv - FIFO read-side consumer that serializes bytes onto a bit stream
// Purpose: pops bytes from the FIFO, shifts them out bit-serially with optional even
//   parity, counts empty reads and backs off before retrying.
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   en_i            level enable; keep draining while 1
//   bus             master side of fifo_byte_serializer_if (FIFO read + tx stream)
//   busy_o          FSM not idle
//   underrun_cnt_o  saturating count of empty reads
module fifo_byte_serializer
  import fifo_byte_serializer_pkg::*;
#(
  parameter int DATA_W      = FIFO_DATA_W,
  parameter int MSB_FIRST   = 1,
  parameter int PARITY_EN   = 0,
  parameter int BACKOFF_CYC = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  fifo_byte_serializer_if.master bus,
  output logic                   busy_o,
  output logic [7:0]             underrun_cnt_o
);

  localparam int FRAME_W = DATA_W + PARITY_EN;
  localparam int IDX_W   = $clog2(FRAME_W);
  localparam int BO_W    = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam logic [BO_W-1:0]  BO_LAST  = BO_W'(BACKOFF_CYC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic [7:0]       und_q, und_d;
  logic             ren_q;

  logic               load;
  logic               shift;
  logic               sout;
  logic [FRAME_W-1:0] frame;
  logic               tx_valid;

  // Parity sits at the tail of the frame in send order.
  generate
    if (PARITY_EN != 0) begin : g_par
      logic par;
      assign par = ^bus.fifo_dout;
      if (MSB_FIRST != 0) begin : g_msb
        assign frame = {bus.fifo_dout, par};
      end else begin : g_lsb
        assign frame = {par, bus.fifo_dout};
      end
    end else begin : g_nopar
      assign frame = bus.fifo_dout;
    end
  endgenerate

  fifo_byte_serializer_piso_shift #(
    .W         (FRAME_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .data_i  (frame),
    .shift_i (shift),
    .bit_o   (sout)
  );

  assign tx_valid = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bo_d    = bo_q;
    und_d   = und_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // fifo_error only means "empty read" in this cycle
        if (bus.fifo_error) begin
          und_d   = sat_inc8(und_q);
          bo_d    = '0;
          state_d = ST_BACKOFF;
        end else begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.tx_ready) begin
          shift = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = en_i ? ST_REQ : ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_BACKOFF: begin
        if (bo_q == BO_LAST) begin
          bo_d    = '0;
          state_d = en_i ? ST_REQ : ST_IDLE;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bo_q    <= '0;
      und_q   <= '0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bo_q    <= bo_d;
      und_q   <= und_d;
      // strobe is a flop that mirrors entry into REQ, so it is one cycle wide
      ren_q   <= (state_d == ST_REQ);
    end
  end

  assign bus.fifo_ren   = ren_q;
  assign bus.tx_valid   = tx_valid;
  assign bus.tx_bit     = sout;
  assign bus.tx_last    = tx_valid && (idx_q == LAST_IDX);
  assign busy_o         = (state_q != ST_IDLE);
  assign underrun_cnt_o = und_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb/tb_fifo_byte_serializer.sv - randomized self-checking bench for fifo_byte_serializer
module tb_fifo_byte_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, en1;
  logic       rdy;
  logic       busy0, busy1;
  logic [7:0] ucnt0, ucnt1;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] fq[2][$];
  bit         xb[2][$];
  bit         xl[2][$];
  int         und[2];
  int         rens[2];
  int         per_exp[2];
  int         per_seen[2];
  int         last_ren[2];
  bit         hold[2];
  bit         prv_ren[2];
  bit         prv_stall[2];
  bit         prv_bit[2];
  bit         prv_last[2];

  always #5 clk = ~clk;

  fifo_byte_serializer_if #(.DATA_W(8)) bus0 ();
  fifo_byte_serializer_if #(.DATA_W(8)) bus1 ();

  assign bus0.tx_ready = rdy;
  assign bus1.tx_ready = rdy;

  fifo_byte_serializer #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(0), .BACKOFF_CYC(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en0), .bus(bus0), .busy_o(busy0), .underrun_cnt_o(ucnt0)
  );

  fifo_byte_serializer #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(1), .BACKOFF_CYC(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en1), .bus(bus1), .busy_o(busy1), .underrun_cnt_o(ucnt1)
  );

  function automatic int fw(input int k);
    return (k == 0) ? 8 : 9;
  endfunction

  function automatic int bo(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected stream for one popped byte: data bits in send order, then parity if enabled.
  task automatic expand(input int k, input logic [7:0] b);
    for (int i = 0; i < fw(k); i++) begin
      if (i == 8)      xb[k].push_back(^b);
      else if (k == 0) xb[k].push_back(b[7-i]);
      else             xb[k].push_back(b[i]);
      xl[k].push_back(i == fw(k) - 1);
    end
  endtask

  // FIFO model plus stream monitor for one DUT, evaluated on the falling edge.
  task automatic step(input int k, input logic ren, input logic valid, input logic txb,
                      input logic last, input logic [7:0] dcur, input logic ecur,
                      output logic [7:0] dnew, output logic enew);
    logic [7:0] b;
    dnew = dcur;
    enew = ecur;
    if (rst) begin
      xb[k].delete(); xl[k].delete(); fq[k].delete();
      und[k] = 0; hold[k] = 0; prv_ren[k] = 0; prv_stall[k] = 0;
      dnew = 8'h00; enew = 1'b0;
    end else begin
      if (prv_ren[k]) chk($sformatf("ren_gap%0d", k), ren, 0);
      if (prv_stall[k]) begin
        chk($sformatf("hold_valid%0d", k), valid, 1);
        chk($sformatf("hold_bit%0d", k), txb, prv_bit[k]);
        chk($sformatf("hold_last%0d", k), last, prv_last[k]);
      end
      if (valid && rdy) begin
        if (xb[k].size() == 0) chk($sformatf("unexpected_bit%0d", k), valid, 0);
        else begin
          chk($sformatf("bit%0d", k), txb, xb[k].pop_front());
          chk($sformatf("last%0d", k), last, xl[k].pop_front());
        end
      end
      prv_stall[k] = valid && !rdy;
      prv_bit[k]   = txb;
      prv_last[k]  = last;
      if (per_exp[k] != per_seen[k]) begin
        per_seen[k] = per_exp[k];
        last_ren[k] = -1;
      end
      if (ren) begin
        rens[k]++;
        if (per_exp[k] != 0 && last_ren[k] >= 0)
          chk($sformatf("ren_period%0d", k), cyc - last_ren[k], per_exp[k]);
        last_ren[k] = cyc;
        if (fq[k].size() != 0) begin
          b = fq[k].pop_front();
          dnew = b; enew = 1'b0;
          expand(k, b);
        end else begin
          und[k]++;
          dnew = 8'($urandom); enew = 1'b1;
        end
        hold[k] = 1;
      end else if (hold[k]) begin
        hold[k] = 0;
      end else begin
        // error noise outside the response cycle must be ignored
        dnew = 8'($urandom); enew = 1'($urandom_range(0, 1));
      end
      prv_ren[k] = ren;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] d;
    logic       e;
    cyc++;
    step(0, bus0.fifo_ren, bus0.tx_valid, bus0.tx_bit, bus0.tx_last, bus0.fifo_dout, bus0.fifo_error, d, e);
    bus0.fifo_dout  = d;
    bus0.fifo_error = e;
    step(1, bus1.fifo_ren, bus1.tx_valid, bus1.tx_bit, bus1.tx_last, bus1.fifo_dout, bus1.fifo_error, d, e);
    bus1.fifo_dout  = d;
    bus1.fifo_error = e;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ren0"}, bus0.fifo_ren, 0);  chk({tag, "_ren1"}, bus1.fifo_ren, 0);
    chk({tag, "_vld0"}, bus0.tx_valid, 0);  chk({tag, "_vld1"}, bus1.tx_valid, 0);
    chk({tag, "_bit0"}, bus0.tx_bit, 0);    chk({tag, "_bit1"}, bus1.tx_bit, 0);
    chk({tag, "_last0"}, bus0.tx_last, 0);  chk({tag, "_last1"}, bus1.tx_last, 0);
    chk({tag, "_busy0"}, busy0, 0);         chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_ucnt0"}, ucnt0, 0);         chk({tag, "_ucnt1"}, ucnt1, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    en0 = 0; en1 = 0;
    while ((busy0 || busy1) && n < 300) begin
      tick(); n++;
    end
    chk({tag, "_idle_timeout"}, busy0 | busy1, 0);
    chk({tag, "_drain0"}, xb[0].size(), 0);
    chk({tag, "_drain1"}, xb[1].size(), 0);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: ready random
  task automatic drive(input string tag, input int mode, input int max);
    int n = 0;
    while (n < max && (fq[0].size() != 0 || fq[1].size() != 0 || busy0 || busy1)) begin
      en0 = (fq[0].size() != 0);
      en1 = (fq[1].size() != 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tick(); n++;
    end
    chk({tag, "_timeout"}, (n < max), 1);
    rdy = 1'b1;
    wait_idle(tag);
  endtask

  task automatic chk_ucnt(input string tag);
    chk({tag, "_ucnt0"}, ucnt0, sat255(und[0]));
    chk({tag, "_ucnt1"}, ucnt1, sat255(und[1]));
  endtask

  task automatic empty_run(input int cycles);
    per_exp[0] = 2 + bo(0);
    per_exp[1] = 2 + bo(1);
    rdy = 1'b1; en0 = 1; en1 = 1;
    repeat (cycles) tick();
    per_exp[0] = 0; per_exp[1] = 0;
    wait_idle("empty");
  endtask

  initial begin
    int n, b0, b1, nb;
    rst = 1; en0 = 0; en1 = 0; rdy = 0;
    per_exp[0] = 0; per_exp[1] = 0;
    tick(); tick();
    chk_quiet("rst");
    rst = 0;
    tick();
    chk_quiet("idle");

    // 0xA5 MSB-first on dut0; 0x07 LSB-first + parity on dut1; en drops in SHIFT
    fq[0].push_back(8'hA5); fq[1].push_back(8'h07);
    rdy = 1; b0 = rens[0]; b1 = rens[1];
    en0 = 1; en1 = 1; n = 0;
    while (!bus0.tx_valid && n < 20) begin tick(); n++; end
    chk("latency", n, 3);
    wait_idle("single");
    chk("single_rens0", rens[0] - b0, 1);
    chk("single_rens1", rens[1] - b1, 1);

    // en dropped in the cycle after fifo_ren
    fq[0].push_back(8'h5A); fq[1].push_back(8'hC3);
    b0 = rens[0]; b1 = rens[1];
    en0 = 1; en1 = 1; n = 0;
    while (!bus0.fifo_ren && n < 10) begin tick(); n++; end
    tick();
    en0 = 0; en1 = 0;
    wait_idle("drop");
    chk("drop_rens0", rens[0] - b0, 1);
    chk("drop_rens1", rens[1] - b1, 1);

    // back-to-back throughput with ready held
    b0 = rens[0]; b1 = rens[1];
    for (int i = 0; i < 4; i++) begin
      fq[0].push_back(8'($urandom)); fq[1].push_back(8'($urandom));
    end
    per_exp[0] = fw(0) + 2; per_exp[1] = fw(1) + 2;
    drive("b2b", 0, 500);
    per_exp[0] = 0; per_exp[1] = 0;
    chk("b2b_rens0", rens[0] - b0, 4);
    chk("b2b_rens1", rens[1] - b1, 4);

    // toggling ready, two bytes
    b0 = rens[0]; b1 = rens[1];
    fq[0].push_back(8'h3C); fq[0].push_back(8'h81);
    fq[1].push_back(8'h3C); fq[1].push_back(8'h81);
    drive("toggle", 1, 500);
    chk("toggle_rens0", rens[0] - b0, 2);
    chk("toggle_rens1", rens[1] - b1, 2);
    chk_ucnt("toggle");

    // short empty run, counter not saturated
    empty_run(30);
    chk_ucnt("empty_short");

    // random bytes with random ready
    b0 = rens[0]; b1 = rens[1];
    nb = 10;
    for (int i = 0; i < nb; i++) begin
      fq[0].push_back(8'($urandom)); fq[1].push_back(8'($urandom));
    end
    drive("rand", 2, 3000);
    chk("rand_rens0", rens[0] - b0, nb);
    chk("rand_rens1", rens[1] - b1, nb);
    chk_ucnt("rand");

    // 300+ empty reads saturate the counter
    empty_run(1850);
    chk("sat_ucnt0", ucnt0, 255);
    chk("sat_ucnt1", ucnt1, 255);

    // reset asserted mid-SHIFT
    for (int i = 0; i < 3; i++) begin
      fq[0].push_back(8'($urandom)); fq[1].push_back(8'($urandom));
    end
    rdy = 1; en0 = 1; en1 = 1; n = 0;
    while (!bus0.tx_valid && n < 20) begin tick(); n++; end
    tick(); tick();
    rst = 1;
    tick();
    chk_quiet("midrst");
    tick();
    rst = 0; en0 = 0; en1 = 0;
    tick();
    chk_quiet("postrst");

    // recovery after reset
    fq[0].push_back(8'h96); fq[1].push_back(8'h96);
    drive("recover", 2, 300);
    chk_ucnt("recover");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
